// File: rtl/d_sram_bridge.sv
// Bridges the MEM-stage load/store port onto an SRAM-like data bus.
// One transaction at a time; the pipeline is stalled until the data phase completes.
module d_sram_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [3:0]  mem_sel,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_flush,
    input  logic        pipe_adv,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic        req_r;
    logic        wr_r;
    logic [1:0]  size_r;
    logic [3:0]  wstrb_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        discard_r;

    logic        issue_s;
    logic        in_req_s;
    logic        in_wait_s;
    logic        drop_data_s;

    // Decode of the current state plus the request-start condition.
    always_comb begin
        issue_s     = 1'b0;
        in_req_s    = 1'b0;
        in_wait_s   = 1'b0;
        drop_data_s = 1'b0;
        case (state_r)
            ST_IDLE: issue_s   = mem_en & ~mem_flush;
            ST_REQ:  in_req_s  = 1'b1;
            ST_WAIT: in_wait_s = 1'b1;
            ST_DONE: issue_s   = 1'b0;
            default: issue_s   = 1'b0;
        endcase
        // A flush arriving in the same cycle as data_ok also kills the result.
        if (in_wait_s) begin
            drop_data_s = discard_r | mem_flush;
        end else begin
            drop_data_s = 1'b0;
        end
    end

    // The stall is combinational so the very first MEM cycle is already held.
    always_comb begin
        mem_stall = issue_s | in_req_s | in_wait_s;
    end

    // Transaction FSM with registered bus outputs and load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            req_r     <= 1'b0;
            wr_r      <= 1'b0;
            size_r    <= 2'd0;
            wstrb_r   <= 4'b0000;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            rdata_r   <= 32'd0;
            discard_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    discard_r <= 1'b0;
                    if (issue_s) begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                        wr_r    <= mem_wr;
                        size_r  <= mem_size;
                        wstrb_r <= mem_wr ? mem_sel : 4'b0000;
                        addr_r  <= mem_addr;
                        wdata_r <= mem_wdata;
                    end else begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok) begin
                        // Address accepted: the data phase must be drained even if flushed.
                        state_r   <= ST_WAIT;
                        req_r     <= 1'b0;
                        discard_r <= mem_flush;
                    end else if (mem_flush) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end else begin
                        state_r <= ST_REQ;
                        req_r   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    req_r <= 1'b0;
                    if (data_data_ok) begin
                        discard_r <= 1'b0;
                        if (drop_data_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_DONE;
                            rdata_r <= data_rdata;
                        end
                    end else begin
                        state_r   <= ST_WAIT;
                        discard_r <= drop_data_s;
                    end
                end
                ST_DONE: begin
                    req_r <= 1'b0;
                    if (pipe_adv || mem_flush) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_r     <= 1'b0;
                    discard_r <= 1'b0;
                end
            endcase
        end
    end

    assign data_req   = req_r;
    assign data_wr    = wr_r;
    assign data_size  = size_r;
    assign data_wstrb = wstrb_r;
    assign data_addr  = addr_r;
    assign data_wdata = wdata_r;
    assign mem_rdata  = rdata_r;

endmodule

// File: tb/tb_d_sram_bridge.sv
// Directed self-checking bench for d_sram_bridge.
module tb_d_sram_bridge;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic        mem_wr;
    logic [3:0]  mem_sel;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_flush;
    logic        pipe_adv;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_cmp;
    int n_err;

    d_sram_bridge dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_sel(mem_sel), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_flush(mem_flush),
        .pipe_adv(pipe_adv), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; mem_sel = 4'h0; mem_size = 2'd0;
        mem_addr = 32'd0; mem_wdata = 32'd0; mem_flush = 1'b0; pipe_adv = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        #3;
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_wstrb", {28'd0, data_wstrb}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        mem_en = 1'b1; #1;
        chk("rst_stall_en", {31'd0, mem_stall}, 32'd1);
        mem_en = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();

        // Zero-wait word load
        mem_en = 1'b1; mem_wr = 1'b0; mem_addr = 32'h0000_1004; mem_size = 2'd2; mem_sel = 4'hF;
        #1; chk("ld_c0_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        chk("ld_c1_req", {31'd0, data_req}, 32'd1);
        chk("ld_c1_wstrb", {28'd0, data_wstrb}, 32'd0);
        chk("ld_c1_addr", data_addr, 32'h0000_1004);
        chk("ld_c1_size", {30'd0, data_size}, 32'd2);
        chk("ld_c1_stall", {31'd0, mem_stall}, 32'd1);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("ld_c2_req", {31'd0, data_req}, 32'd0);
        chk("ld_c2_stall", {31'd0, mem_stall}, 32'd1);
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        tick();
        data_data_ok = 1'b0;
        chk("ld_c3_rdata", mem_rdata, 32'hDEAD_BEEF);
        chk("ld_c3_stall", {31'd0, mem_stall}, 32'd0);
        pipe_adv = 1'b1;
        tick();
        pipe_adv = 1'b0; mem_en = 1'b0;
        #1;
        chk("ld_idle_stall", {31'd0, mem_stall}, 32'd0);
        chk("ld_idle_req", {31'd0, data_req}, 32'd0);

        // Byte store with address handshake delayed three cycles
        mem_en = 1'b1; mem_wr = 1'b1; mem_addr = 32'h0000_0002; mem_sel = 4'b0100;
        mem_wdata = 32'h00AB_0000; mem_size = 2'd0;
        tick();
        mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'd0; mem_sel = 4'hF; mem_size = 2'd2;
        for (int i = 0; i < 3; i++) begin
            chk("st_req", {31'd0, data_req}, 32'd1);
            chk("st_addr", data_addr, 32'h0000_0002);
            chk("st_wstrb", {28'd0, data_wstrb}, 32'h0000_0004);
            chk("st_size", {30'd0, data_size}, 32'd0);
            chk("st_wr", {31'd0, data_wr}, 32'd1);
            chk("st_wdata", data_wdata, 32'h00AB_0000);
            data_addr_ok = (i == 2);
            tick();
        end
        data_addr_ok = 1'b0;
        chk("st_wait_req", {31'd0, data_req}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h0000_0055;
        tick();
        data_data_ok = 1'b0;
        chk("st_done_rdata", mem_rdata, 32'h0000_0055);
        pipe_adv = 1'b1;
        tick();
        pipe_adv = 1'b0; mem_en = 1'b0; mem_wr = 1'b0;

        // Flush in REQ before address accepted
        mem_en = 1'b1; mem_addr = 32'h0000_0100; mem_size = 2'd2; mem_sel = 4'hF;
        tick();
        chk("fr_req", {31'd0, data_req}, 32'd1);
        mem_flush = 1'b1;
        tick();
        mem_flush = 1'b0; mem_en = 1'b0;
        #1;
        chk("fr_req_drop", {31'd0, data_req}, 32'd0);
        chk("fr_stall", {31'd0, mem_stall}, 32'd0);
        chk("fr_rdata", mem_rdata, 32'h0000_0055);

        // Flush in WAIT: late data must be discarded
        mem_en = 1'b1; mem_addr = 32'h0000_0200;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; mem_flush = 1'b1; mem_en = 1'b0;
        #1; chk("fw_stall0", {31'd0, mem_stall}, 32'd1);
        tick();
        mem_flush = 1'b0;
        #1;
        chk("fw_stall1", {31'd0, mem_stall}, 32'd1);
        chk("fw_req", {31'd0, data_req}, 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        tick();
        data_data_ok = 1'b0;
        chk("fw_rdata", mem_rdata, 32'h0000_0055);
        mem_en = 1'b1; #1;
        chk("fw_idle_not_done", {31'd0, mem_stall}, 32'd1);
        mem_en = 1'b0;

        // Flush in REQ coincident with address accept
        tick();
        mem_en = 1'b1; mem_addr = 32'h0000_0204;
        tick();
        data_addr_ok = 1'b1; mem_flush = 1'b1; mem_en = 1'b0;
        tick();
        data_addr_ok = 1'b0; mem_flush = 1'b0;
        #1; chk("fa_wait_stall", {31'd0, mem_stall}, 32'd1);
        data_data_ok = 1'b1; data_rdata = 32'hAAAA_AAAA;
        tick();
        data_data_ok = 1'b0;
        chk("fa_rdata", mem_rdata, 32'h0000_0055);
        mem_en = 1'b1; #1;
        chk("fa_idle", {31'd0, mem_stall}, 32'd1);
        mem_en = 1'b0;

        // DONE held without pipe_adv; stray data_ok ignored
        tick();
        mem_en = 1'b1; mem_addr = 32'h0000_0300;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        tick();
        data_data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("dh_rdata", mem_rdata, 32'hCAFE_F00D);
            chk("dh_req", {31'd0, data_req}, 32'd0);
            chk("dh_stall", {31'd0, mem_stall}, 32'd0);
            data_data_ok = (i == 0); data_rdata = 32'h1111_1111;
            tick();
            data_data_ok = 1'b0;
        end
        chk("dh_rdata_end", mem_rdata, 32'hCAFE_F00D);
        chk("dh_stall_end", {31'd0, mem_stall}, 32'd0);
        pipe_adv = 1'b1;
        tick();
        pipe_adv = 1'b0;
        chk("dh_idle", {31'd0, mem_stall}, 32'd1);
        mem_en = 1'b0;

        // Reset asserted in WAIT
        tick();
        mem_en = 1'b1; mem_addr = 32'h0000_0400;
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; mem_en = 1'b0;
        #1; chk("rw_pre_stall", {31'd0, mem_stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rw_req", {31'd0, data_req}, 32'd0);
        chk("rw_rdata", mem_rdata, 32'd0);
        chk("rw_addr", data_addr, 32'd0);
        chk("rw_stall", {31'd0, mem_stall}, 32'd0);
        rst = 1'b1;
        data_data_ok = 1'b1; data_rdata = 32'h9999_9999;
        tick();
        data_data_ok = 1'b0;
        chk("rw_stray_rdata", mem_rdata, 32'd0);
        chk("rw_stray_req", {31'd0, data_req}, 32'd0);
        chk("rw_stray_stall", {31'd0, mem_stall}, 32'd0);
        mem_en = 1'b1; #1;
        chk("rw_idle", {31'd0, mem_stall}, 32'd1);

        // Reset asserted in REQ
        tick();
        chk("rr_req", {31'd0, data_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rr_req_drop", {31'd0, data_req}, 32'd0);
        rst = 1'b1; mem_en = 1'b0;
        tick();
        chk("rr_req_after", {31'd0, data_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/d_sram_bridge.md
D_SRAM_BRIDGE -- requirements
Module: d_sram_bridge

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 mem_en  in  1  MEM-stage instruction is a load/store this cycle.
REQ-005 mem_wr  in  1  1 = store, 0 = load; valid with mem_en.
REQ-006 mem_sel  in  4  byte strobes from MEM byte-select logic.
REQ-007 mem_size  in  2  access size from MEM: 0 = byte, 1 = half, 2 = word.
REQ-008 mem_addr  in  32  effective address (ALU result).
REQ-009 mem_wdata  in  32  lane-aligned store data.
REQ-010 mem_flush  in  1  exception/ERET flush of the MEM stage.
REQ-011 pipe_adv  in  1  MEM-stage instruction leaves MEM this cycle.
REQ-012 mem_rdata  out  32  raw loaded word, consumed by MEM load extraction.
REQ-013 mem_stall  out  1  hold the MEM stage and all upstream stages.
REQ-014 data_req, data_wr  out  1 each  SRAM-like bus request and write flag.
REQ-015 data_size  out  2; data_wstrb  out  4; data_addr  out  32; data_wdata  out  32.
REQ-016 data_addr_ok, data_data_ok  in  1 each; data_rdata  in  32.

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: when mem_en=1 and mem_flush=0, the block SHALL capture mem_wr, mem_size, mem_sel, mem_addr and mem_wdata into bus registers and go to REQ.
REQ-019 IDLE: mem_en=1 with mem_flush=1 SHALL issue nothing and stay in IDLE.
REQ-020 data_req SHALL be 1 exactly in REQ. Bus outputs SHALL come only from registers and stay stable throughout REQ.
REQ-021 data_wstrb SHALL equal the captured mem_sel for stores and 4'b0000 for loads.
REQ-022 REQ: data_addr_ok=1 SHALL move to WAIT. data_addr_ok=0 SHALL stay in REQ.
REQ-023 REQ: mem_flush=1 with data_addr_ok=0 SHALL drop data_req next cycle and return to IDLE.
REQ-024 REQ: mem_flush=1 with data_addr_ok=1 SHALL set a discard flag and move to WAIT.
REQ-025 WAIT: data_data_ok=1 SHALL register data_rdata into mem_rdata and go to DONE. If the discard flag is set, it SHALL instead go to IDLE, clear the flag and leave mem_rdata unchanged.
REQ-026 WAIT: mem_flush=1 SHALL set the discard flag; the block SHALL still wait for data_data_ok.
REQ-027 data_data_ok outside WAIT SHALL be ignored.
REQ-028 DONE: mem_rdata SHALL be held. pipe_adv=1 or mem_flush=1 SHALL return the FSM to IDLE.
REQ-029 No new request SHALL be issued from DONE. An access needs at least one IDLE cycle after each return.
REQ-030 mem_stall SHALL equal (IDLE & mem_en & ~mem_flush) | REQ | WAIT, combinationally.
REQ-031 mem_stall SHALL be 0 in DONE.
REQ-032 Minimum latency, mem_en to mem_stall=0: 3 cycles, with addr_ok in the first REQ cycle and data_ok in the first WAIT cycle.
REQ-033 At most one transaction SHALL be outstanding on the bus.

Reset
REQ-034 On rst=0, asynchronously and at once, the block SHALL enter IDLE and clear the discard flag.
REQ-035 On rst=0, every data_* output and mem_rdata SHALL be 0; mem_stall SHALL be 0 unless mem_en=1.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction without waiting for data_ok.

Verification
REQ-037 Load, zero wait: mem_en=1, mem_wr=0, mem_addr=0x00001004, mem_size=2. Bus returns addr_ok in cycle 1 and data_ok with rdata=0xDEADBEEF in cycle 2. Required: data_wstrb=0; mem_stall=1 for cycles 0-2; mem_rdata=0xDEADBEEF and mem_stall=0 in cycle 3.
REQ-038 Store byte, addr_ok delayed 3 cycles: mem_addr=0x00000002, mem_sel=4'b0100, mem_wdata=0x00AB0000. Required: data_req held 3 cycles with stable data_addr=0x00000002, data_wstrb=4'b0100, data_size=0.
REQ-039 Flush in REQ before addr_ok. Required: data_req=0 next cycle, FSM in IDLE, mem_stall=0 with mem_en=0.
REQ-040 Flush in WAIT. Required: the later data_ok with rdata=0x12345678 leaves mem_rdata unchanged, the FSM returns to IDLE, and no DONE cycle occurs.
REQ-041 DONE held with pipe_adv=0 for 2 cycles. Required: mem_rdata stable and no data_req. Then pipe_adv=1 gives IDLE.
REQ-042 rst=0 asserted in WAIT. Required: data_req=0 and mem_rdata=0 at once; a stray data_ok after reset is ignored.
